// File: rtl/dmem_copy_engine.sv
// dmem_copy_engine: block-copy master for the byte-addressed data memory.
// Moves len bytes src->dst in word/half/byte chunks, one read then one write each.
module dmem_copy_engine #(
    parameter int LEN_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      src_i,
    input  logic [31:0]      dst_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [31:0]      addr_o,
    output logic [1:0]       MemRead_o,
    output logic [1:0]       MemWrite_o,
    output logic [31:0]      WriteData_o,
    input  logic [31:0]      ReadData_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [31:0]      r_buf;
    logic [LEN_W-1:0] r_rem;

    logic [1:0]       w_code;
    logic [2:0]       w_n;
    logic [31:0]      w_n_addr;
    logic [LEN_W-1:0] w_n_len;

    // Largest access that still fits in the remaining byte count.
    always_comb begin
        w_code = 2'd0;
        w_n    = 3'd0;
        if (r_rem >= LEN_W'(4)) begin
            w_code = 2'd3;
            w_n    = 3'd4;
        end else if (r_rem >= LEN_W'(2)) begin
            w_code = 2'd2;
            w_n    = 3'd2;
        end else if (r_rem == LEN_W'(1)) begin
            w_code = 2'd1;
            w_n    = 3'd1;
        end
    end

    assign w_n_addr = {29'd0, w_n};
    assign w_n_len  = LEN_W'(w_n);

    // State register and copy datapath (cursors, remaining count, data buffer).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_rem   <= '0;
            r_buf   <= '0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_src <= src_i;
                        r_dst <= dst_i;
                        r_rem <= len_i;
                    end
                end
                S_READ: begin
                    r_buf <= ReadData_i;
                end
                S_WRITE: begin
                    r_src <= r_src + w_n_addr;
                    r_dst <= r_dst + w_n_addr;
                    r_rem <= r_rem - w_n_len;
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state selection; a zero-length start goes straight to DONE.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_next = (len_i == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                w_next = S_WRITE;
            end
            S_WRITE: begin
                w_next = (r_rem == w_n_len) ? S_DONE : S_READ;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Memory-port outputs decoded from state; accesses are masked during reset.
    always_comb begin
        busy_o      = 1'b0;
        done_o      = 1'b0;
        addr_o      = '0;
        MemRead_o   = 2'd0;
        MemWrite_o  = 2'd0;
        WriteData_o = '0;
        unique case (r_state)
            S_READ: begin
                busy_o    = 1'b1;
                addr_o    = r_src;
                MemRead_o = w_code;
            end
            S_WRITE: begin
                busy_o      = 1'b1;
                addr_o      = r_dst;
                MemWrite_o  = w_code;
                WriteData_o = r_buf;
            end
            S_DONE: begin
                done_o = 1'b1;
            end
            default: begin
            end
        endcase
        if (rst_i) begin
            MemRead_o  = 2'd0;
            MemWrite_o = 2'd0;
        end
    end

endmodule

// File: doc/dmem_copy_engine.md
Name: dmem_copy_engine

Overview:
- Block-copy initiator (DMA-style master) for the byte-addressed data memory.
- Copies `len` bytes from a source to a destination address, one chunk at a time, with a read access followed by a write access.
- Drives the data memory's 2-bit access codes: 0 = no access, 1 = byte, 2 = halfword, 3 = word.
- Sits beside the pipeline's memory stage and is muxed onto the data memory port by the integrator; this block contains no arbitration.

Parameters:
- LEN_W, 16, width of the byte-count input and of the internal remaining-bytes counter.

Ports:
- clk_i  input  1  clock; all state changes on posedge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  begin a copy; sampled only in IDLE.
- src_i  input  32  source byte address.
- dst_i  input  32  destination byte address.
- len_i  input  LEN_W  byte count.
- busy_o  output  1  high in READ and WRITE.
- done_o  output  1  one-cycle completion pulse.
- addr_o  output  32  byte address to data memory.
- MemRead_o  output  2  read access code to data memory.
- MemWrite_o  output  2  write access code to data memory.
- WriteData_o  output  32  write data to data memory; byte 0 in bits [7:0].
- ReadData_i  input  32  combinational read data from data memory; unused upper bytes arrive as zero.

Behaviour:
- Clocking: one clock, clk_i. rst_i is synchronous, active-high; on a reset edge state goes to IDLE and all registers clear (src_cur, dst_cur, rem, buf, state).
- Output decode: outputs are decoded combinationally from state. While rst_i=1, MemRead_o and MemWrite_o are forced to 0.
- Reset values: busy_o=0, done_o=0, addr_o=0, MemRead_o=0, MemWrite_o=0, WriteData_o=0.
- Chunk size n and code, chosen from rem:
  - rem>=4: n=4, code 3.
  - rem in {2,3}: n=2, code 2.
  - rem=1: n=1, code 1.
- No alignment requirement; chunks are the byte-lane access codes only.
- IDLE:
  - All outputs 0.
  - If start_i=1: latch src_cur=src_i, dst_cur=dst_i, rem=len_i.
  - Next state is DONE if len_i=0 (no memory access issued), else READ.
- READ:
  - addr_o=src_cur, MemRead_o=code(rem), MemWrite_o=0, busy_o=1, WriteData_o=0.
  - At the edge, buf<=ReadData_i; next state WRITE.
- WRITE:
  - addr_o=dst_cur, MemWrite_o=code(rem), MemRead_o=0, WriteData_o=buf, busy_o=1.
  - At the edge: src_cur+=n, dst_cur+=n, rem-=n.
  - Next state is DONE if rem==n, else READ.
- DONE: done_o=1 for exactly one cycle, busy_o=0, no access; next state IDLE.
- Latency: done_o is asserted 2*C+1 cycles after the start edge, where C = number of chunks (len 0 gives 1 cycle).
- start_i outside IDLE, including during DONE, is ignored; no queueing.
- Arithmetic:
  - Address increments wrap modulo 2^32.
  - rem never underflows because n<=rem is guaranteed.
- Overlapping regions: copy is forward, chunk-by-chunk; each read completes before its paired write. The result for dst>src overlap is whatever that order produces; it is not corrected.
- Reset mid-copy:
  - Any state returns to IDLE and the copy is abandoned.
  - No access is issued during or after the reset cycle; chunks already written remain in memory.
  - No done_o pulse is produced.
- Out-of-range addresses are not checked; bounds are the caller's responsibility.

Test Plan:
- Word copy: preload mem[0..7]=01..08; start src=0 dst=16 len=8. Required:
  - Codes READ3@0, WRITE3@16, READ3@4, WRITE3@20.
  - done_o 5 cycles after start; mem[16..23]=01..08.
- Mixed chunks: len=7, src=0, dst=8. Required:
  - Write codes 3,2,1 at dst 8, 12, 14.
  - The halfword write carries WriteData_o[31:16]=0.
  - done_o after 7 cycles; mem[8..14] matches.
- Zero length: start len=0. Required: done_o high on the 2nd cycle; MemRead_o and MemWrite_o stay 0 throughout.
- Start while busy: pulse start_i with a different src/dst during WRITE of an 8-byte copy. Required: ignored; original copy completes unchanged and exactly one done_o pulse occurs.
- Reset mid-operation: assert rst_i during the second READ of an 8-byte copy. Required:
  - MemWrite_o=0 from that cycle on; state IDLE; no done_o.
  - mem[20..23] unmodified; a following start works normally.
- Address wrap: src=0xFFFFFFFC, len=8. Required: second READ addr_o=0x00000000.
